// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the integer register file slice: data width,
// architectural register-address width, the x0 address and a register
// address type.
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 is hardwired to zero: never stored, never pending.
  localparam reg_addr_t X0 = '0;

endpackage : riscv_pkg

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
// Pending-write scoreboard for the register file. One bit per architectural
// register marks an issued-but-not-written-back destination. Decode uses the
// per-port busy flags and the aggregate stall to hold on RAW hazards.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   ren[NRD]        per-port read enable (only gates stall)
//   raddr[NRD*AW]   flattened read addresses, port i at [i*AW +: AW]
//   we, waddr       writeback port; clears the pending bit
//   alloc_en/rd     issue port; sets the pending bit
//   flush           clears every pending bit
//   rbusy[NRD]      combinational busy per read port
//   stall           OR of (ren & rbusy)
// ----------------------------------------------------------------------------
module rf_scoreboard
  import riscv_pkg::*;
#(
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD-1:0]    ren,
  input  logic [NRD*AW-1:0] raddr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_rd,
  input  logic              flush,
  output logic [NRD-1:0]    rbusy,
  output logic              stall
);

  localparam logic BYP = (BYPASS != 0);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Later assignments override earlier ones, giving the priority
  // flush > alloc (set) > writeback (clear). Bit 0 is forced low last.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned and a latch can never be inferred.
    pending_nxt = pending;
    if (we)       pending_nxt[waddr]    = 1'b0;
    if (alloc_en) pending_nxt[alloc_rd] = 1'b1;
    if (flush)    pending_nxt           = '0;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  // A same-cycle writeback to the read address masks busy when bypassing,
  // because the forwarded write data is captured on that same edge.
  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic [AW-1:0] ra;
    assign ra       = raddr[i*AW +: AW];
    assign rbusy[i] = pending[ra] & ~(BYP & we & (waddr == ra));
  end

  assign stall = |(ren & rbusy);

endmodule : rf_scoreboard

// File: rtl/riscv_regfile_mp.sv
// ----------------------------------------------------------------------------
// riscv_regfile_mp
// Multi-read-port RISC-V integer register file with registered read data,
// optional write-first bypass, hardwired x0 and an integrated pending-write
// scoreboard (rf_scoreboard).
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   ren[NRD]          per-port read enable; rdata holds when low
//   raddr[NRD*AW]     flattened read addresses, port i at [i*AW +: AW]
//   rdata[NRD*XLEN]   registered read data, flattened the same way
//   rbusy[NRD]        combinational: port address has an outstanding write
//   we, waddr, wdata  single write port; writes to x0 are dropped
//   alloc_en/rd       mark a destination pending at issue
//   flush             clear all pending bits
//   stall             OR over ports of (ren & rbusy)
// ----------------------------------------------------------------------------
module riscv_regfile_mp
  import riscv_pkg::*;
#(
  parameter  int XLEN   = riscv_pkg::XLEN,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      ren,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_rd,
  input  logic                flush,
  output logic                stall
);

  localparam logic BYP = (BYPASS != 0);

  // x0 has no storage; entries start at 1.
  logic [XLEN-1:0] regs [1:NREG-1];

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the register array is reset on purpose -- architectural state
    // must read zero after reset, so the array becomes flops, not RAM.
    if (!rst) begin
      for (int k = 1; k < NREG; k++) regs[k] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rval;
    logic [XLEN-1:0] rd_q;

    assign ra = raddr[i*AW +: AW];

    // Write-first: with bypass, a same-edge write to this address wins over
    // the stored (pre-edge) contents.
    always_comb begin
      rval = '0;
      if (ra == '0)                         rval = '0;
      else if (BYP && we && (waddr == ra))  rval = wdata;
      else                                  rval = regs[ra];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       rd_q <= '0;
      else if (ren[i]) rd_q <= rval;
    end

    assign rdata[i*XLEN +: XLEN] = rd_q;
  end

  rf_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .ren      (ren),
    .raddr    (raddr),
    .we       (we),
    .waddr    (waddr),
    .alloc_en (alloc_en),
    .alloc_rd (alloc_rd),
    .flush    (flush),
    .rbusy    (rbusy),
    .stall    (stall)
  );

endmodule : riscv_regfile_mp

// File: tb/tb_riscv_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_riscv_regfile_mp
// Two register files driven by one stimulus stream: instance A (NRD=4,
// BYPASS=1) and instance B (NRD=2, BYPASS=0, using ports 0..1). A behavioural
// model (plain arrays) predicts read data, busy and stall for both; a compare
// process checks every cycle, and directed scenarios pin literal values.
// ----------------------------------------------------------------------------
module tb_riscv_regfile_mp;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]      ren;
  logic [4*AW-1:0] raddr;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XL-1:0]   wdata;
  logic            alloc_en;
  logic [AW-1:0]   alloc_rd;
  logic            flush;

  logic [4*XL-1:0] rdata_a;
  logic [3:0]      rbusy_a;
  logic            stall_a;
  logic [2*XL-1:0] rdata_b;
  logic [1:0]      rbusy_b;
  logic            stall_b;

  riscv_regfile_mp #(.XLEN(XL), .NREG(NR), .NRD(4), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata_a),
    .rbusy(rbusy_a), .we(we), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .flush(flush), .stall(stall_a)
  );

  riscv_regfile_mp #(.XLEN(XL), .NREG(NR), .NRD(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .ren(ren[1:0]), .raddr(raddr[2*AW-1:0]),
    .rdata(rdata_b), .rbusy(rbusy_b), .we(we), .waddr(waddr), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .flush(flush), .stall(stall_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [XL-1:0] m_mem [NR];
  bit            m_pend[NR];
  logic [XL-1:0] m_ra  [4];
  logic [XL-1:0] m_rb  [2];

  function automatic int port_addr(int p);
    return int'(raddr[p*AW +: AW]);
  endfunction

  function automatic logic [XL-1:0] model_read(int a, bit byp);
    if (a == 0) return '0;
    if (byp && we && int'(waddr) == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic bit model_busy(int a, bit byp);
    return m_pend[a] && !(byp && we && int'(waddr) == a);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NR; k++) begin m_mem[k] = '0; m_pend[k] = 0; end
      for (int i = 0; i < 4; i++) m_ra[i] = '0;
      for (int i = 0; i < 2; i++) m_rb[i] = '0;
    end else begin
      for (int i = 0; i < 4; i++) if (ren[i]) m_ra[i] = model_read(port_addr(i), 1);
      for (int i = 0; i < 2; i++) if (ren[i]) m_rb[i] = model_read(port_addr(i), 0);
      if (we && waddr != 0) m_mem[waddr] = wdata;
      if (flush) begin
        for (int k = 0; k < NR; k++) m_pend[k] = 0;
      end else begin
        if (we)       m_pend[waddr]    = 0;
        if (alloc_en) m_pend[alloc_rd] = 1;
      end
      m_pend[0] = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      bit sa, sb;
      sa = 0; sb = 0;
      for (int i = 0; i < 4; i++) begin
        bit ba;
        ba = (rst === 1'b1) && model_busy(port_addr(i), 1);
        sa |= ren[i] & ba;
        check($sformatf("A rdata%0d", i), rdata_a[i*XL +: XL], m_ra[i]);
        check($sformatf("A rbusy%0d", i), rbusy_a[i], ba);
      end
      for (int i = 0; i < 2; i++) begin
        bit bb;
        bb = (rst === 1'b1) && model_busy(port_addr(i), 0);
        sb |= ren[i] & bb;
        check($sformatf("B rdata%0d", i), rdata_b[i*XL +: XL], m_rb[i]);
        check($sformatf("B rbusy%0d", i), rbusy_b[i], bb);
      end
      check("A stall", stall_a, sa);
      check("B stall", stall_b, sb);
    end
  end

  // ---------------- directed + random stimulus ----------------
  function automatic logic [XL-1:0] rd_a(int p);
    return rdata_a[p*XL +: XL];
  endfunction

  function automatic logic [XL-1:0] rd_b(int p);
    return rdata_b[p*XL +: XL];
  endfunction

  task automatic idle();
    ren = '0; raddr = '0; we = 0; waddr = '0; wdata = '0;
    alloc_en = 0; alloc_rd = '0; flush = 0;
  endtask

  task automatic set_ra(int p, int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(int a, logic [XL-1:0] d);
    we = 1; waddr = AW'(a); wdata = d;
  endtask

  task automatic alloc(int a);
    alloc_en = 1; alloc_rd = AW'(a);
  endtask

  // Let the current inputs be sampled at the next edge; return 2 ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7))
                                       : int'($urandom_range(0, NR-1));
  endfunction

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    cmp_en = 1;

    // Seed x5 and x1..x4.
    wr(5, 32'hCAFE_0005); tick();
    for (int k = 1; k <= 4; k++) begin wr(k, 32'h100 + k); tick(); end

    // Write-first bypass vs. no forwarding.
    idle(); wr(5, 32'h1234_5678); ren = 4'b0001; set_ra(0, 5); tick();
    check("bypass A new", rd_a(0), 32'h1234_5678);
    check("nobypass B old", rd_b(0), 32'hCAFE_0005);
    idle(); ren = 4'b0001; set_ra(0, 5); tick();
    check("nobypass B next", rd_b(0), 32'h1234_5678);

    // x0 immunity.
    idle(); wr(0, 32'hDEAD_BEEF); alloc(0); tick();
    idle(); ren = 4'b0001; set_ra(0, 0); #1;
    check("x0 rbusy", rbusy_a[0], 1'b0);
    tick();
    check("x0 rdata A", rd_a(0), 32'h0);
    check("x0 rdata B", rd_b(0), 32'h0);

    // RAW hazard on x7.
    idle(); alloc(7); tick();
    idle(); ren = 4'b0010; set_ra(1, 7); #1;
    check("raw busy A", rbusy_a[1], 1'b1);
    check("raw stall A", stall_a, 1'b1);
    check("raw busy B", rbusy_b[1], 1'b1);
    wr(7, 32'hAA); #1;
    check("wb busy A", rbusy_a[1], 1'b0);
    check("wb stall A", stall_a, 1'b0);
    check("wb busy B", rbusy_b[1], 1'b1);
    tick();
    check("wb rdata A", rd_a(1), 32'hAA);
    check("wb rdata B old", rd_b(1), 32'h0);
    we = 0; #1;
    check("post-wb busy B", rbusy_b[1], 1'b0);
    tick();
    check("post-wb rdata B", rd_b(1), 32'hAA);

    // Alloc/writeback collision on x9.
    idle(); alloc(9); tick();
    alloc(9); wr(9, 32'h55); tick();
    idle(); ren = 4'b0001; set_ra(0, 9); #1;
    check("collide busy", rbusy_a[0], 1'b1);
    tick();
    check("collide rdata A", rd_a(0), 32'h55);
    check("collide rdata B", rd_b(0), 32'h55);

    // Flush beats alloc.
    idle(); alloc(3); tick();
    alloc(4); tick();
    idle(); flush = 1; alloc(6); tick();
    idle(); ren = 4'hF; set_ra(0, 3); set_ra(1, 4); set_ra(2, 6); set_ra(3, 9); #1;
    check("flush busy A", rbusy_a, 4'h0);
    check("flush stall A", stall_a, 1'b0);
    check("flush busy B", rbusy_b, 2'h0);
    tick();
    check("flush rdata3", rd_a(3), 32'h55);

    // Four ports in parallel.
    idle(); ren = 4'hF;
    for (int p = 0; p < 4; p++) set_ra(p, p + 1);
    tick();
    for (int p = 0; p < 4; p++)
      check($sformatf("quad rdata%0d", p), rd_a(p), 32'h101 + p);

    // Reset mid-run, with a pending alloc and an in-flight write.
    idle(); alloc(12); tick();
    idle(); wr(10, 32'h7777_0010); ren = 4'hF;
    #2 rst = 1'b0;
    #1;
    for (int p = 0; p < 4; p++)
      check($sformatf("rst rdata%0d", p), rd_a(p), 32'h0);
    check("rst stall", stall_a, 1'b0);
    tick();
    idle(); rst = 1'b1; tick();
    for (int base = 1; base < NR; base += 4) begin
      idle();
      for (int p = 0; p < 4; p++)
        if (base + p < NR) begin ren[p] = 1'b1; set_ra(p, base + p); end
      #1;
      check("post-rst rbusy", rbusy_a, 4'h0);
      check("post-rst stall", stall_a, 1'b0);
      tick();
      for (int p = 0; p < 4; p++)
        if (base + p < NR)
          check($sformatf("post-rst x%0d", base + p), rd_a(p), 32'h0);
    end

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 2000; c++) begin
      ren = 4'($urandom);
      for (int p = 0; p < 4; p++) set_ra(p, rnd_addr());
      we       = ($urandom_range(0, 1) != 0);
      waddr    = AW'(rnd_addr());
      wdata    = $urandom;
      alloc_en = ($urandom_range(0, 9) < 3);
      alloc_rd = AW'(rnd_addr());
      flush    = ($urandom_range(0, 39) == 0);
      tick();
    end

    idle();
    @(negedge clk);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_riscv_regfile_mp
